alu_input_fsm: RTL

ALU_INPUT_FSM -- requirements
Module: alu_input_fsm

---
 rtl/alu_io_pkg.sv | 18 +
 rtl/debouncer.sv | 48 ++++
 rtl/alu_input_fsm.sv | 78 +++++++
 3 files changed

// File: rtl/alu_io_pkg.sv
// Shared types for the ALU operand-entry block: data width, state encoding and LED mapping.
package alu_io_pkg;

    localparam int unsigned DATA_WIDTH = 16;

    typedef enum logic [1:0] {
        StWaitA  = 2'd0,
        StWaitB  = 2'd1,
        StWaitOp = 2'd2,
        StShow   = 2'd3
    } alu_state_e;

    // LED bit index equals the state encoding.
    function automatic logic [3:0] state_onehot(alu_state_e s);
        return 4'b0001 << s;
    endfunction

endpackage

// File: rtl/debouncer.sv
// Button conditioner: 2-flop synchronizer, stability counter and a registered one-cycle
// press pulse on each debounced rising level.
module debouncer #(
    parameter int unsigned DEBOUNCE_CYCLES = 1000000
) (
    input  logic clk,
    input  logic reset,
    input  logic btn,
    output logic press
);

    localparam int unsigned CntW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CntW-1:0] CntMax = CntW'(DEBOUNCE_CYCLES - 1);

    logic            sync1;
    logic            sync2;
    logic [CntW-1:0] cnt;
    logic            level;
    logic            level_prev;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1      <= 1'b0;
            sync2      <= 1'b0;
            cnt        <= '0;
            level      <= 1'b0;
            level_prev <= 1'b0;
            press      <= 1'b0;
        end else begin
            sync1 <= btn;
            sync2 <= sync1;
            // Level flips only after DEBOUNCE_CYCLES consecutive mismatching cycles.
            if (sync2 != level) begin
                if (cnt == CntMax) begin
                    level <= ~level;
                    cnt   <= '0;
                end else begin
                    cnt <= cnt + CntW'(1);
                end
            end else begin
                cnt <= '0;
            end
            level_prev <= level;
            press      <= level & ~level_prev;
        end
    end

endmodule

// File: rtl/alu_input_fsm.sv
// Collects operand A, operand B and opcode from the switches on successive enter presses
// and presents them, fully registered, to the ALU.
module alu_input_fsm
    import alu_io_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 1000000
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] sw,
    input  logic                  btn_enter,
    input  logic                  btn_clear,
    output logic [DATA_WIDTH-1:0] a_out,
    output logic [DATA_WIDTH-1:0] b_out,
    output logic [DATA_WIDTH-1:0] op_out,
    output logic [3:0]            state_leds,
    output logic                  operands_valid
);

    alu_state_e state;
    logic       enter_press;
    logic       clear_press;

    debouncer #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_enter_db (
        .clk  (clk),
        .reset(reset),
        .btn  (btn_enter),
        .press(enter_press)
    );

    debouncer #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_clear_db (
        .clk  (clk),
        .reset(reset),
        .btn  (btn_clear),
        .press(clear_press)
    );

    always_ff @(posedge clk) begin
        // Clear outranks enter when both events land on the same edge.
        if (reset || clear_press) begin
            state          <= StWaitA;
            state_leds     <= state_onehot(StWaitA);
            a_out          <= '0;
            b_out          <= '0;
            op_out         <= '0;
            operands_valid <= 1'b0;
        end else if (enter_press) begin
            unique case (state)
                StWaitA: begin
                    a_out      <= sw;
                    state      <= StWaitB;
                    state_leds <= state_onehot(StWaitB);
                end
                StWaitB: begin
                    b_out      <= sw;
                    state      <= StWaitOp;
                    state_leds <= state_onehot(StWaitOp);
                end
                StWaitOp: begin
                    op_out         <= sw;
                    operands_valid <= 1'b1;
                    state          <= StShow;
                    state_leds     <= state_onehot(StShow);
                end
                StShow: begin
                    operands_valid <= 1'b0;
                    state          <= StWaitA;
                    state_leds     <= state_onehot(StWaitA);
                end
            endcase
        end
    end

endmodule
